regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port register file with busy scoreboard and clear sweep.
// Define REGFILE_BYPASS_EN to forward a same-cycle qualified write onto matching read ports.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic                     clr_req,
   output logic                     clr_busy
);

   typedef enum logic {
      IDLE,
      SWEEP
   } state_t;

   localparam logic [ADDR_W:0]   LIM      = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH-1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] w_idx_nxt;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic              w_clr_busy;
   logic              w_wr_q;
   logic              w_iss_q;

   function automatic logic in_rng(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < LIM);
   endfunction

   assign w_clr_busy = (r_state == SWEEP);
   assign clr_busy   = w_clr_busy;

   assign w_wr_q  = wr_en && (wr_addr != '0) && in_rng(wr_addr)
                    && !w_clr_busy;
   assign w_iss_q = iss_en && (iss_addr != '0) && in_rng(iss_addr)
                    && !w_clr_busy;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      unique case (r_state)
         IDLE: begin
            if (clr_req) begin
               w_state_nxt = SWEEP;
               w_idx_nxt   = IDX_ONE;
            end
         end
         SWEEP: begin
            // index saturates at the last register instead of wrapping
            if (r_idx == IDX_LAST) begin
               w_state_nxt = IDLE;
            end else begin
               w_idx_nxt = r_idx + IDX_ONE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_busy <= '0;
      end else if (w_clr_busy) begin
         r_mem[r_idx]  <= '0;
         r_busy[r_idx] <= 1'b0;
      end else begin
         if (w_wr_q) begin
            r_mem[wr_addr]  <= wr_data;
            r_busy[wr_addr] <= 1'b0;
         end
         // issue follows write so a same-address pair leaves busy set
         if (w_iss_q) begin
            r_busy[iss_addr] <= 1'b1;
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic w_iss_same;
   assign w_iss_same = w_iss_q && (iss_addr == wr_addr);
`endif

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_a;
      logic              w_ok;
      assign w_a  = rd_addr[k*ADDR_W +: ADDR_W];
      assign w_ok = rst_n && in_rng(w_a);
`ifdef REGFILE_BYPASS_EN
      logic w_byp;
      assign w_byp = w_wr_q && (wr_addr == w_a);
      assign rd_data[k*DATA_W +: DATA_W] = !w_ok ? '0 :
                                           w_byp ? wr_data : r_mem[w_a];
      assign rd_busy[k] = w_ok && (w_byp ? w_iss_same : r_busy[w_a]);
`else
      assign rd_data[k*DATA_W +: DATA_W] = w_ok ? r_mem[w_a] : '0;
      assign rd_busy[k] = w_ok && r_busy[w_a];
`endif
   end

endmodule
